// File: rtl/alu_pkg.sv
// Shared ALU result-stage types: widths, opcodes, and the FIFO entry layout.
// Result vectors are [0:DATA_W-1] with bit 0 as the MSB, matching the ALU datapath.
package alu_pkg;

  localparam int DATA_W      = 4;
  localparam int OP_W        = 3;
  localparam int FIFO_DEPTH  = 4;
  localparam int FIFO_ADDR_W = 2;
  localparam int ENTRY_W     = DATA_W + OP_W + 2;

  localparam logic [OP_W-1:0] OP_AND = 3'd0;
  localparam logic [OP_W-1:0] OP_OR  = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR = 3'd2;
  localparam logic [OP_W-1:0] OP_ADD = 3'd3;
  localparam logic [OP_W-1:0] OP_SUB = 3'd4;
  localparam logic [OP_W-1:0] OP_NOT = 3'd5;

  typedef struct packed {
    logic [0:DATA_W-1] v;
    logic [OP_W-1:0]   op;
    logic              zero;
    logic              par;
  } entry_t;

  function automatic entry_t make_entry(input logic [0:DATA_W-1] v, input logic [OP_W-1:0] op);
    entry_t e;
    e.v    = v;
    e.op   = op;
    e.zero = ~|v;
    e.par  = ^v;
    return e;
  endfunction

endpackage

// File: rtl/alu_fifo_mem.sv
// Entry storage: DEPTH x W register array, one synchronous write port, one async read port.
// Read data follows raddr combinationally; no reset so the array maps onto plain flops or LUT RAM.
module alu_fifo_mem #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2,
  parameter int W      = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [W-1:0]      wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [W-1:0]      rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/alu_result_fifo.sv
// ALU result FIFO with zero/parity flags captured at push; push at edge N is visible in cycle N+1.
// in_ready depends only on occupancy (never on out_ready); a stalled in_valid sets sticky stall_seen.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:DATA_W-1] in_v,
  input  logic [OP_W-1:0]   in_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:DATA_W-1] out_v,
  output logic [OP_W-1:0]   out_op,
  output logic              out_zero,
  output logic              out_par,
  output logic [ADDR_W:0]   count,
  output logic              stall_seen,
  input  logic              clr_stall
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push;
  logic              pop;
  entry_t            wr_entry;
  entry_t            rd_entry;
  logic [ENTRY_W-1:0] rd_raw;

  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign wr_entry  = make_entry(in_v, in_op);

  alu_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .W      (ENTRY_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_raw)
  );

  assign rd_entry = entry_t'(rd_raw);

  // Head fields are masked while empty so stale storage never leaks to the consumer.
  assign out_v    = out_valid ? rd_entry.v    : '0;
  assign out_op   = out_valid ? rd_entry.op   : '0;
  assign out_zero = out_valid ? rd_entry.zero : 1'b0;
  assign out_par  = out_valid ? rd_entry.par  : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Set has priority over clear so a stall in the clearing cycle is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_seen <= 1'b0;
    end else if (in_valid && !in_ready) begin
      stall_seen <= 1'b1;
    end else if (clr_stall) begin
      stall_seen <= 1'b0;
    end
  end

endmodule
